imem_arbiter: RTL

Arbitrates a single synchronous instruction-memory port between the core's instruction-fetch stage and the program loader/debug port. Accepts one request per cycle, checks alignment and range, drives the memory word port, and returns each read response one cycle later to the owning requester. Fetch has priority; a starvation counter guarantees the loader forward progress. Sits between the fetch stage, the loader, and the IMEM array.

---
 rtl/imem_arbiter_pkg.sv | 22 ++
 rtl/imem_arbiter_if.sv | 49 ++++
 rtl/imem_addr_chk.sv | 22 ++
 rtl/imem_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: default widths,
// requester ownership encoding and the one-cycle response record.
package imem_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH      = 32;
  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_WORD_ADDR_WIDTH = 18;
  localparam int DEF_STARVE_LIMIT    = 4;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LD = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   err;
    logic   is_write;
  } rsp_t;

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundles the fetch, loader and memory-side signals of the IMEM arbiter;
// slave is the arbiter's view, master is the surrounding environment's view.
interface imem_arbiter_if #(
  parameter int ADDR_WIDTH      = imem_arbiter_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = imem_arbiter_pkg::DEF_DATA_WIDTH,
  parameter int WORD_ADDR_WIDTH = imem_arbiter_pkg::DEF_WORD_ADDR_WIDTH
);

  logic                       if_req;
  logic [ADDR_WIDTH-1:0]      if_addr;
  logic                       if_gnt;
  logic                       if_rvalid;
  logic [DATA_WIDTH-1:0]      if_rdata;
  logic                       if_err;

  logic                       ld_req;
  logic                       ld_we;
  logic [ADDR_WIDTH-1:0]      ld_addr;
  logic [DATA_WIDTH-1:0]      ld_wdata;
  logic                       ld_gnt;
  logic                       ld_rvalid;
  logic [DATA_WIDTH-1:0]      ld_rdata;
  logic                       ld_err;

  logic                       mem_en;
  logic                       mem_we;
  logic [WORD_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic [DATA_WIDTH-1:0]      mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_gnt, ld_rvalid, ld_rdata, ld_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_gnt, ld_rvalid, ld_rdata, ld_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/imem_addr_chk.sv
// Combinational byte-address check: flags misaligned or out-of-range
// addresses and extracts the memory word index. Zero latency, no flow control.
module imem_addr_chk
  import imem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int WORD_ADDR_WIDTH = DEF_WORD_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]      addr_i,
  output logic [WORD_ADDR_WIDTH-1:0] word_o,
  output logic                       err_o
);

  logic misaligned;
  logic out_of_range;

  assign misaligned   = |addr_i[1:0];
  assign out_of_range = |addr_i[ADDR_WIDTH-1:WORD_ADDR_WIDTH+2];
  assign word_o       = addr_i[WORD_ADDR_WIDTH+1:2];
  assign err_o        = misaligned | out_of_range;

endmodule

// File: rtl/imem_arbiter.sv
// Fetch/loader arbiter for one IMEM port: 1-cycle response latency, no response back-pressure,
// loser of arbitration holds its request. Loader writes exist only with IMEM_LOADER_WR_EN defined.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int WORD_ADDR_WIDTH = DEF_WORD_ADDR_WIDTH,
  parameter int STARVE_LIMIT    = DEF_STARVE_LIMIT
) (
  input  logic          clk,
  input  logic          rst,
  imem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]           starve_q, starve_d;
  rsp_t                       rsp_q, rsp_d;

  logic [WORD_ADDR_WIDTH-1:0] if_word, ld_word;
  logic                       if_aerr, ld_aerr;
  logic                       if_gnt, ld_gnt;
  logic                       wr_ok;
  logic                       starved;

  logic                       mem_en, mem_we;
  logic [WORD_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;

  logic                       pend;
  logic                       if_rv, ld_rv;
  logic [DATA_WIDTH-1:0]      rdata;

  imem_addr_chk #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .WORD_ADDR_WIDTH (WORD_ADDR_WIDTH)
  ) u_if_chk (
    .addr_i (bus.if_addr),
    .word_o (if_word),
    .err_o  (if_aerr)
  );

  imem_addr_chk #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .WORD_ADDR_WIDTH (WORD_ADDR_WIDTH)
  ) u_ld_chk (
    .addr_i (bus.ld_addr),
    .word_o (ld_word),
    .err_o  (ld_aerr)
  );

`ifdef IMEM_LOADER_WR_EN
  assign wr_ok = 1'b1;
`else
  assign wr_ok = 1'b0;
`endif

  assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (!rst) begin
      if (bus.ld_req && (!bus.if_req || starved)) begin
        ld_gnt = 1'b1;
      end else if (bus.if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Counts consecutive denied loader cycles; any gap or grant restarts it.
  always_comb begin
    starve_d = '0;
    if (bus.ld_req && !ld_gnt) begin
      starve_d = starved ? starve_q : starve_q + 1'b1;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rsp_d     = '0;
    if (if_gnt) begin
      rsp_d.valid = 1'b1;
      rsp_d.owner = OWNER_IF;
      rsp_d.err   = if_aerr;
      if (!if_aerr) begin
        mem_en   = 1'b1;
        mem_addr = if_word;
      end
    end else if (ld_gnt) begin
      rsp_d.valid    = 1'b1;
      rsp_d.owner    = OWNER_LD;
      rsp_d.is_write = bus.ld_we;
      rsp_d.err      = ld_aerr | (bus.ld_we & ~wr_ok);
      if (!rsp_d.err) begin
        mem_en    = 1'b1;
        mem_we    = bus.ld_we & wr_ok;
        mem_addr  = ld_word;
        mem_wdata = bus.ld_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      rsp_q    <= '0;
    end else begin
      starve_q <= starve_d;
      rsp_q    <= rsp_d;
    end
  end

  // A response still in the register while rst is high must not leak out.
  assign pend  = rsp_q.valid & ~rst;
  assign if_rv = pend & (rsp_q.owner == OWNER_IF);
  assign ld_rv = pend & (rsp_q.owner == OWNER_LD);
  assign rdata = (pend & ~rsp_q.err & ~rsp_q.is_write) ? bus.mem_rdata : '0;

  assign bus.if_gnt    = if_gnt;
  assign bus.ld_gnt    = ld_gnt;
  assign bus.if_rvalid = if_rv;
  assign bus.if_err    = if_rv & rsp_q.err;
  assign bus.if_rdata  = if_rv ? rdata : '0;
  assign bus.ld_rvalid = ld_rv;
  assign bus.ld_err    = ld_rv & rsp_q.err;
  assign bus.ld_rdata  = ld_rv ? rdata : '0;

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule
